// File: rtl/mgmt_wb_arb_pkg.sv
// Shared types and constants for the management Wishbone arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter state encoding, master index constants, default
// watchdog threshold and the round-robin pick helper.
package mgmt_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

  // Round-robin choice between two requesters. On a tie the master that
  // did not win last time is chosen. With no request the result is M_CPU
  // and is ignored by the caller.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    logic pick;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = M_DBG;
    end else begin
      pick = M_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus-cycle watchdog: counts consecutive unacknowledged strobe cycles of the owner.
// Latency: timeout is combinational in the cycle the count sits at TIMEOUT-1 with no ack.
// Backpressure: none; observes the shared bus only.
//
// Ports: busy (a master owns the bus), owner_stb (owner strobe),
// ack (slave acknowledge), timeout (one-cycle abort request).
module wb_bus_watchdog
  import mgmt_wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic core_clk,
  input  logic core_rstn,
  input  logic busy,
  input  logic owner_stb,
  input  logic ack,
  output logic timeout
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count is zero whenever the bus is not owned, so entering BUSY
  // always starts from zero. An ack or a low owner strobe restarts it.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (busy && owner_stb && !ack) begin
      if (cnt_q == THRESH) begin
        // The arbiter leaves BUSY next cycle, so the count can drop to zero.
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mgmt_wb_arbiter.sv
// Two-master Wishbone arbiter (CPU, debug bridge) onto the user-project bus, with timeout abort.
// Latency: grant visible one cycle after request; ack/data return is combinational.
// Backpressure: non-owner waits with cyc/stb held; owner keeps the bus until it drops cyc.
//
// Ports: m0_* CPU master, m1_* debug master, mprj_* shared user bus,
// mprj_wb_iena user return-path enable, err_cnt saturating timeout count,
// err_clr synchronous clear of err_cnt. CNT_W must hold TIMEOUT-1.
module mgmt_wb_arbiter
  import mgmt_wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic             core_clk,
  input  logic             core_rstn,

  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [31:0]      m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,

  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [31:0]      m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,

  output logic             mprj_cyc_o,
  output logic             mprj_stb_o,
  output logic             mprj_we_o,
  output logic [3:0]       mprj_sel_o,
  output logic [31:0]      mprj_adr_o,
  output logic [31:0]      mprj_dat_o,
  input  logic             mprj_ack_i,
  input  logic [31:0]      mprj_dat_i,
  output logic             mprj_wb_iena,

  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  arb_state_e       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        req0, req1;
  logic        own_cyc, own_stb, own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr, own_dat;
  logic        busy, abort;
  logic        wd_timeout, to_abort;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Owner view of the request side; only meaningful while BUSY.
  assign own_cyc = (gnt_q == M_DBG) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (gnt_q == M_DBG) ? m1_stb_i : m0_stb_i;
  assign own_we  = (gnt_q == M_DBG) ? m1_we_i  : m0_we_i;
  assign own_sel = (gnt_q == M_DBG) ? m1_sel_i : m0_sel_i;
  assign own_adr = (gnt_q == M_DBG) ? m1_adr_i : m0_adr_i;
  assign own_dat = (gnt_q == M_DBG) ? m1_dat_i : m0_dat_i;

  assign busy  = (state_q == BUSY);
  assign abort = (state_q == ABORT);

  wb_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .core_clk  (core_clk),
    .core_rstn (core_rstn),
    .busy      (busy),
    .owner_stb (own_stb),
    .ack       (mprj_ack_i),
    .timeout   (wd_timeout)
  );

  // A release by the owner takes precedence over a timeout in the same
  // cycle: the master has already given the bus up.
  assign to_abort = busy & own_cyc & wd_timeout;

  // Next-state, grant and round-robin pointer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = rr_pick(req0, req1, last_q);
          last_d  = gnt_d;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (to_abort) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timeout counter. A clear in the same cycle as a timeout still counts
  // the new timeout, leaving 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end
    if (to_abort && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q   <= IDLE;
      gnt_q     <= M_CPU;
      last_q    <= M_DBG;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Bus muxes. Everything is gated by registered state, so an
  // asynchronous reset silences all outputs immediately.
  always_comb begin
    mprj_cyc_o   = 1'b0;
    mprj_stb_o   = 1'b0;
    mprj_we_o    = 1'b0;
    mprj_sel_o   = '0;
    mprj_adr_o   = '0;
    mprj_dat_o   = '0;
    mprj_wb_iena = 1'b0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m0_dat_o     = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    m1_dat_o     = '0;
    if (busy) begin
      mprj_cyc_o   = own_cyc;
      mprj_stb_o   = own_stb;
      mprj_we_o    = own_we;
      mprj_sel_o   = own_sel;
      mprj_adr_o   = own_adr;
      mprj_dat_o   = own_dat;
      mprj_wb_iena = 1'b1;
      if (gnt_q == M_DBG) begin
        m1_ack_o = mprj_ack_i;
        m1_dat_o = mprj_dat_i;
      end else begin
        m0_ack_o = mprj_ack_i;
        m0_dat_o = mprj_dat_i;
      end
    end
    if (abort) begin
      m0_err_o = (gnt_q == M_CPU);
      m1_err_o = (gnt_q == M_DBG);
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mgmt_wb_arbiter.sv
// Bench for mgmt_wb_arbiter: directed scenarios plus randomized masters and slave,
// with a per-cycle reference model of ownership, fairness and the timeout rule.
// Outputs are sampled 2 ns after the rising edge (directed) and on the falling edge (model).
module tb_mgmt_wb_arbiter;

  localparam int TO = 8;
  localparam int CW = 8;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;

  logic [1:0]  cyc = '0, stb = '0, we = '0;
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [1:0]  m_ack, m_err;
  logic [31:0] m_rdat [2];

  logic        mprj_cyc_o, mprj_stb_o, mprj_we_o, mprj_wb_iena;
  logic [3:0]  mprj_sel_o;
  logic [31:0] mprj_adr_o, mprj_dat_o;
  logic        mprj_ack_i = 1'b0;
  logic [31:0] mprj_dat_i = '0;
  logic [CW-1:0] err_cnt;
  logic        err_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 core_clk = ~core_clk;

  mgmt_wb_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .core_clk     (core_clk),
    .core_rstn    (core_rstn),
    .m0_cyc_i     (cyc[0]),
    .m0_stb_i     (stb[0]),
    .m0_we_i      (we[0]),
    .m0_sel_i     (sel[0]),
    .m0_adr_i     (adr[0]),
    .m0_dat_i     (wdat[0]),
    .m0_ack_o     (m_ack[0]),
    .m0_err_o     (m_err[0]),
    .m0_dat_o     (m_rdat[0]),
    .m1_cyc_i     (cyc[1]),
    .m1_stb_i     (stb[1]),
    .m1_we_i      (we[1]),
    .m1_sel_i     (sel[1]),
    .m1_adr_i     (adr[1]),
    .m1_dat_i     (wdat[1]),
    .m1_ack_o     (m_ack[1]),
    .m1_err_o     (m_err[1]),
    .m1_dat_o     (m_rdat[1]),
    .mprj_cyc_o   (mprj_cyc_o),
    .mprj_stb_o   (mprj_stb_o),
    .mprj_we_o    (mprj_we_o),
    .mprj_sel_o   (mprj_sel_o),
    .mprj_adr_o   (mprj_adr_o),
    .mprj_dat_o   (mprj_dat_o),
    .mprj_ack_i   (mprj_ack_i),
    .mprj_dat_i   (mprj_dat_i),
    .mprj_wb_iena (mprj_wb_iena),
    .err_cnt      (err_cnt),
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 none, else master index. A timed-out cycle spends one cycle
  // in "aborting" where only the error to the old owner is visible.
  int   md_owner = -1;
  bit   md_abort = 1'b0;
  int   md_abort_who = 0;
  int   md_wait = 0;     // consecutive unacked strobe cycles of the owner
  int   md_last = 1;     // master that won the most recent grant
  int   md_errs = 0;
  logic [1:0] ack_seen = '0, err_seen = '0;

  initial begin
    forever begin
      @(negedge core_clk);
      begin
        bit   live;
        int   oi;
        logic [1:0] e_ack, e_err;
        logic [31:0] e_dat [2];
        oi   = (md_owner == 1) ? 1 : 0;
        live = core_rstn && !md_abort && (md_owner >= 0);
        for (int i = 0; i < 2; i++) begin
          e_ack[i] = live && (oi == i) && mprj_ack_i;
          e_dat[i] = (live && (oi == i)) ? mprj_dat_i : 32'h0;
          e_err[i] = core_rstn && md_abort && (md_abort_who == i);
        end
        check("mprj_cyc",  mprj_cyc_o,   live ? cyc[oi]  : 1'b0);
        check("mprj_stb",  mprj_stb_o,   live ? stb[oi]  : 1'b0);
        check("mprj_we",   mprj_we_o,    live ? we[oi]   : 1'b0);
        check("mprj_sel",  mprj_sel_o,   live ? sel[oi]  : 4'h0);
        check("mprj_adr",  mprj_adr_o,   live ? adr[oi]  : 32'h0);
        check("mprj_dat",  mprj_dat_o,   live ? wdat[oi] : 32'h0);
        check("iena",      mprj_wb_iena, live);
        check("m_ack",     m_ack,        e_ack);
        check("m_err",     m_err,        e_err);
        check("m0_dat",    m_rdat[0],    e_dat[0]);
        check("m1_dat",    m_rdat[1],    e_dat[1]);
        check("err_cnt",   err_cnt,      core_rstn ? md_errs : 0);

        ack_seen = m_ack;
        err_seen = m_err;

        if (!core_rstn) begin
          md_owner = -1; md_abort = 1'b0; md_wait = 0; md_last = 1; md_errs = 0;
        end else begin
          if (err_clr) md_errs = 0;
          if (md_abort) begin
            md_abort = 1'b0;
            md_owner = -1;
          end else if (md_owner >= 0) begin
            if (!cyc[oi]) begin
              md_owner = -1;
            end else if (stb[oi] && !mprj_ack_i) begin
              md_wait++;
              if (md_wait == TO) begin
                md_abort = 1'b1;
                md_abort_who = oi;
                md_errs = (md_errs + 1 > 255) ? 255 : md_errs + 1;
              end
            end else begin
              md_wait = 0;
            end
          end else begin
            bit r0, r1;
            int w;
            r0 = cyc[0] && stb[0];
            r1 = cyc[1] && stb[1];
            if (r0 || r1) begin
              if (r0 && r1) w = (md_last == 0) ? 1 : 0;
              else          w = r1 ? 1 : 0;
              md_owner = w;
              md_last  = w;
              md_wait  = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a);
    cyc[i]  = 1'b1;
    stb[i]  = 1'b1;
    adr[i]  = a;
    wdat[i] = $urandom;
    we[i]   = 1'($urandom_range(0, 1));
    sel[i]  = 4'($urandom_range(0, 15));
  endtask

  task automatic drop(input int i);
    cyc[i] = 1'b0;
    stb[i] = 1'b0;
  endtask

  task automatic run_random(input int ncyc);
    bit act [2];
    int left [2];
    int idle [2];
    int slv_cnt, slv_lat;
    act = '{0, 0}; left = '{0, 0}; idle = '{0, 0};
    slv_cnt = 0; slv_lat = 1;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (err_seen[i] || (ack_seen[i] && left[i] <= 1)) begin
            drop(i);
            act[i]  = 1'b0;
            idle[i] = $urandom_range(0, 3);
          end else if (ack_seen[i]) begin
            left[i]--;
            set_req(i, $urandom);
            stb[i] = ($urandom_range(0, 3) != 0);   // occasional strobe gap
          end else if (!stb[i]) begin
            stb[i] = 1'b1;
          end
        end else if (idle[i] > 0) begin
          idle[i]--;
        end else if ($urandom_range(0, 2) == 0) begin
          act[i]  = 1'b1;
          left[i] = $urandom_range(1, 4);
          set_req(i, $urandom);
        end
      end
      err_clr    = ($urandom_range(0, 63) == 0);
      mprj_dat_i = $urandom;
      #1;
      // Slave: ack on the L-th strobe cycle; L of 9 or more never acks.
      if (mprj_stb_o) begin
        if (slv_cnt == 0) slv_lat = $urandom_range(1, 10);
        slv_cnt++;
        mprj_ack_i = (slv_cnt == slv_lat);
        if (mprj_ack_i) slv_cnt = 0;
      end else begin
        slv_cnt    = 0;
        mprj_ack_i = ($urandom_range(0, 15) == 0);
      end
    end
    drop(0); drop(1);
    mprj_ack_i = 1'b0;
    err_clr    = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      sel[i] = '0; adr[i] = '0; wdat[i] = '0;
    end
    #23;
    check("rst_cyc",  mprj_cyc_o,   1'b0);
    check("rst_iena", mprj_wb_iena, 1'b0);
    check("rst_err",  m_err,        2'b00);
    check("rst_cnt",  err_cnt,      8'd0);
    tick();
    core_rstn = 1'b1;
    tick();

    // Tie out of reset, single CPU read, hand-over to m1, second tie.
    set_req(0, 32'h1000_0000);
    set_req(1, 32'h2000_0000);
    #1 check("tie_idle_cyc", mprj_cyc_o, 1'b0);
    tick(); #1;
    check("tie_gnt0_cyc", mprj_cyc_o, 1'b1);
    check("tie_gnt0_adr", mprj_adr_o, 32'h1000_0000);
    check("tie_gnt0_iena", mprj_wb_iena, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick(); #1 check("rd_wait_ack", m_ack[0], 1'b0);
    end
    tick();
    mprj_ack_i = 1'b1; mprj_dat_i = 32'hDEADBEEF;
    #1;
    check("rd_ack0", m_ack[0], 1'b1);
    check("rd_dat0", m_rdat[0], 32'hDEADBEEF);
    check("rd_ack1", m_ack[1], 1'b0);
    check("rd_dat1", m_rdat[1], 32'h0);
    tick();
    mprj_ack_i = 1'b0; drop(0);
    #1 check("rel_cyc_comb", mprj_cyc_o, 1'b0);
    tick(); #1;
    check("rel_idle_cyc", mprj_cyc_o, 1'b0);
    check("rel_idle_iena", mprj_wb_iena, 1'b0);
    tick(); #1;
    check("m1_gnt_cyc", mprj_cyc_o, 1'b1);
    check("m1_gnt_adr", mprj_adr_o, 32'h2000_0000);
    mprj_ack_i = 1'b1;
    #1 check("m1_ack", m_ack, 2'b10);
    tick();
    mprj_ack_i = 1'b0; drop(1);
    tick();
    set_req(0, 32'h1000_0004);
    set_req(1, 32'h2000_0004);
    tick(); #1 check("tie2_adr", mprj_adr_o, 32'h1000_0004);
    mprj_ack_i = 1'b1;
    tick();
    mprj_ack_i = 1'b0; drop(0); drop(1);
    repeat (2) tick();

    // Timeout with no ack: error at grant+9.
    set_req(0, 32'h3000_0000);
    for (int k = 1; k <= 9; k++) begin
      tick(); #1;
      if (k == 8) check("to_no_err_early", m_err[0], 1'b0);
    end
    check("to_err0",  m_err[0],     1'b1);
    check("to_err1",  m_err[1],     1'b0);
    check("to_cyc",   mprj_cyc_o,   1'b0);
    check("to_iena",  mprj_wb_iena, 1'b0);
    tick();
    drop(0);
    #1 check("to_err_once", m_err[0], 1'b0);
    check("to_cnt", err_cnt, 8'd1);
    tick();

    // Ack on the threshold cycle wins.
    set_req(0, 32'h3000_0004);
    for (int k = 1; k <= 8; k++) tick();
    mprj_ack_i = 1'b1;
    #1 check("thr_ack", m_ack[0], 1'b1);
    tick();
    mprj_ack_i = 1'b0; drop(0);
    #1 check("thr_no_err", m_err[0], 1'b0);
    tick(); #1 check("thr_cnt", err_cnt, 8'd1);

    // Burst hold by m1 while m0 waits.
    set_req(1, 32'h4000_0000);
    tick();
    set_req(0, 32'h5000_0000);
    for (int b = 0; b < 4; b++) begin
      adr[1] = 32'h4000_0000 + 32'(b * 4);
      mprj_ack_i = 1'b1;
      #1;
      check("burst_adr", mprj_adr_o, 32'h4000_0000 + 32'(b * 4));
      check("burst_ack", m_ack, 2'b10);
      tick();
    end
    mprj_ack_i = 1'b0; stb[1] = 1'b0;
    #1 check("burst_hold_adr", mprj_adr_o, 32'h4000_000C);
    tick();
    drop(1);
    #1 check("burst_rel_cyc", mprj_cyc_o, 1'b0);
    tick(); #1 check("burst_idle_cyc", mprj_cyc_o, 1'b0);
    tick(); #1 check("burst_m0_adr", mprj_adr_o, 32'h5000_0000);
    mprj_ack_i = 1'b1;
    tick();
    mprj_ack_i = 1'b0; drop(0);
    tick();

    // Saturation: 260 more timeouts.
    for (int t = 0; t < 260; t++) begin
      bit seen;
      set_req(0, 32'h6000_0000);
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        tick(); #1;
        seen = m_err[0];
      end
      if (!seen) check("sat_err_seen", 1'b0, 1'b1);
      tick();
      drop(0);
    end
    tick(); #1 check("sat_cnt", err_cnt, 8'd255);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 check("clr_cnt", err_cnt, 8'd0);

    // Clear coinciding with a timeout leaves 1.
    set_req(0, 32'h7000_0000);
    for (int k = 1; k <= 9; k++) begin
      tick();
      err_clr = (k == 8);
    end
    #1 check("clr_to_cnt", err_cnt, 8'd1);
    tick();
    drop(0);
    tick();

    run_random(4000);

    // Asynchronous reset in the middle of a BUSY cycle with ack pending.
    set_req(0, 32'h8000_0000);
    tick(); tick();
    mprj_ack_i = 1'b1; mprj_dat_i = 32'hCAFEF00D;
    #1 check("arst_pre_ack", m_ack[0], 1'b1);
    #2 core_rstn = 1'b0;
    #1;
    check("arst_cyc",  mprj_cyc_o,   1'b0);
    check("arst_adr",  mprj_adr_o,   32'h0);
    check("arst_iena", mprj_wb_iena, 1'b0);
    check("arst_ack",  m_ack,        2'b00);
    check("arst_err",  m_err,        2'b00);
    check("arst_dat",  m_rdat[0],    32'h0);
    tick();
    mprj_ack_i = 1'b0; drop(0);
    tick();
    core_rstn = 1'b1;
    set_req(0, 32'h9000_0000);
    set_req(1, 32'hA000_0000);
    tick(); #1 check("arst_tie_adr", mprj_adr_o, 32'h9000_0000);
    mprj_ack_i = 1'b1;
    tick();
    mprj_ack_i = 1'b0; drop(0); drop(1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL sim_timeout: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mgmt_wb_arbiter.md
# mgmt_wb_arbiter

Two-master Wishbone arbiter that shares the management core's exported user-project Wishbone port between the CPU and a debug master (UART debug bridge). It sits between the management core and the user-project wrapper and drives the `mprj_*` bus and `mprj_wb_iena`. It has round-robin fairness, hold-until-release ownership, and a bus-timeout watchdog that terminates hung user-project cycles with an error.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles without `mprj_ack_i` before the cycle is aborted. Legal range 1..255.
- `CNT_W`, default 8: width of the timeout counter and of `err_cnt`.

Ports:
- `core_clk`  in  1  single clock.
- `core_rstn`  in  1  asynchronous, active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  CPU master controls.
- `m0_sel_i`  in  4  CPU byte select.
- `m0_adr_i`, `m0_dat_i`  in  32 each  CPU address and write data.
- `m0_ack_o`, `m0_err_o`  out  1 each  CPU termination.
- `m0_dat_o`  out  32  CPU read data.
- `m1_*`  same set as `m0_*`, for the debug master.
- `mprj_cyc_o`, `mprj_stb_o`, `mprj_we_o`  out  1 each  shared bus controls.
- `mprj_sel_o`  out  4  shared bus byte select.
- `mprj_adr_o`, `mprj_dat_o`  out  32 each  shared bus address and write data.
- `mprj_ack_i`  in  1  slave acknowledge.
- `mprj_dat_i`  in  32  slave read data.
- `mprj_wb_iena`  out  1  enables the user-side return path; high only while a master owns the bus.
- `err_cnt`  out  CNT_W  saturating count of timeouts.
- `err_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner registered in `gnt`, 0 or 1.
  - ABORT: one cycle.
- IDLE → BUSY when any `mX_cyc_i & mX_stb_i` is high.
  - If only one master requests, it wins.
  - If both request, the master other than `last` wins.
  - `last` updates on every grant.
- BUSY:
  - The shared bus outputs are a mux of the owner's inputs.
  - `mprj_cyc_o` is the owner's `cyc`, `mprj_stb_o` is the owner's `stb`.
  - `mprj_ack_i` and `mprj_dat_i` route to the owner only.
  - The non-owner sees `ack=0`, `err=0`, `dat=0`.
- BUSY → IDLE when the owner's `cyc` is low. Ownership persists across back-to-back `stb` within one `cyc`.
- Watchdog:
  - The counter clears on entering BUSY, on `mprj_ack_i`, and whenever the owner's `stb` is low.
  - It increments while the owner's `stb` is high and `mprj_ack_i` is low.
  - At count == `TIMEOUT−1` with no ack, the next state is ABORT.
- ABORT:
  - `mX_err_o` is high for the owner for exactly 1 cycle.
  - `mprj_cyc_o`, `mprj_stb_o` and `mprj_wb_iena` are forced to 0.
  - `err_cnt` increments, saturating at 2^CNT_W−1.
  - Next state is IDLE.
- Outside BUSY, all `mprj_*` outputs are 0.
- Simultaneous events:
  - Ack on the same cycle as the timeout threshold: ack wins, no ABORT.
  - `err_clr` together with a timeout: `err_cnt` becomes 1.
  - The owner dropping `cyc` while a new request arrives from the other master: IDLE for one cycle, then the other master is granted.
- Reset (asynchronous, at any time including mid-cycle):
  - State IDLE, `last`=1 (so m0 wins the first tie), counter 0, `err_cnt` 0.
  - All outputs 0.

## Timing
- Grant latency: request seen in IDLE at cycle N → `gnt` registered → `mprj_cyc_o`/`mprj_stb_o` high at N+1.
- Ack/data path is combinational: `mprj_ack_i` to `mX_ack_o` in 0 cycles, with no registered return.
- Release: owner `cyc` low at cycle N → `mprj_cyc_o` low at N (combinational) → IDLE at N+1 → earliest new grant visible at N+2.
- Timeout: first unacked `stb` cycle counts as 1. `err` is asserted at cycle `TIMEOUT`+1 after the grant cycle.

## Structure
- Package `mgmt_wb_arb_pkg`:
  - State encoding: IDLE=2'd0, BUSY=2'd1, ABORT=2'd2.
  - Master index constants: M_CPU=0, M_DBG=1.
  - Default `TIMEOUT` constant.
- Sub-module `wb_bus_watchdog`: counter, clear/increment logic and threshold compare; outputs a `timeout` pulse.
- The top holds the FSM, the round-robin pointer, the muxes and `err_cnt`.

## Test plan
- Single CPU read: slave acks 3 cycles after `stb` with data 0xDEADBEEF → `m0_ack_o` 1 cycle, `m0_dat_o`=0xDEADBEEF, `m1_ack_o`=0, `mprj_wb_iena` high only during BUSY.
- Tie out of reset: m0 and m1 request on the same cycle → m0 is granted first. After m0 releases, m1 is granted 2 cycles later. On the next tie, m0 is granted.
- Burst hold: m1 holds `cyc` for 4 acked strobes while m0 requests → m0 stays ungranted until m1 drops `cyc`.
- Timeout with `TIMEOUT`=8 and no ack → `m0_err_o` pulses once at grant+9, `mprj_cyc_o` is 0 in that cycle, `err_cnt`=1. Ack landing on the count-7 cycle → normal ack, `err_cnt` unchanged.
- Saturation/clear: force 260 timeouts with CNT_W=8 → `err_cnt`=255. Pulse `err_clr` → 0.
- Asynchronous reset asserted mid-BUSY → all outputs 0 immediately, no ack/err leaks. After release, a fresh tie is granted to m0.
